// File: rtl/p4_shift_sequencer.sv
// p4_shift_sequencer: multi-cycle shift controller for the shared 1-bit 16-bit shifter.
// It loads an operand into the accumulator and then runs one shifter pass per clock.
// Each pass feeds the shifter result back into the accumulator until the count
// runs out. A one-cycle done pulse marks the result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; dout holds the previous result
// SHIFT | one shifter pass per cycle; cnt counts down the remaining passes
// DONE  | done pulse for one cycle; the accumulator is final
module p4_shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amt,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sh_in,
  output logic [1:0]        sh_code,
  input  logic [DATA_W-1:0] sh_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [AMT_W-1:0] CNT_LAST = AMT_W'(1);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [AMT_W-1:0]  cnt;
  logic [1:0]        op_r;
  logic              shift_en;

  // Sequencer: accept, iterate the shifter, pulse done; every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      op_r     <= 2'b00;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= din;
            op_r <= op;
            cnt  <= amt;
            busy <= 1'b1;
            if (amt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= SHIFT;
              shift_en <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= sh_out;
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state    <= DONE;
            shift_en <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          shift_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // The shifter sees the accumulator directly. It sees the latched code only while shifting.
  assign sh_in   = acc;
  assign sh_code = op_r & {2{shift_en}};
  assign dout    = acc;

endmodule

// File: tb/tb_p4_shift_sequencer.sv
// tb_p4_shift_sequencer: randomized and directed self-checking bench.
// The bench holds a 1-bit shifter model and a whole-shift arithmetic reference.
module tb_p4_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] din;
  logic [15:0] sh_in;
  logic [1:0]  sh_code;
  logic [15:0] sh_out;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int checks   = 0;
  int failures = 0;

  p4_shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .din     (din),
    .sh_in   (sh_in),
    .sh_code (sh_code),
    .sh_out  (sh_out),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared single-pass shifter
  always_comb begin
    sh_out = sh_in;
    case (sh_code)
      2'b01:   sh_out = {sh_in[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, sh_in[15:1]};
      2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
      default: sh_out = sh_in;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                            input logic [3:0] a);
    logic signed [15:0] s;
    s = d;
    case (o)
      2'b01:   return d << a;
      2'b10:   return d >> a;
      2'b11:   return s >>> a;
      default: return d;
    endcase
  endfunction

  // Called at a negedge in IDLE. start is raised at once, so each call also
  // checks that a start in the first IDLE cycle after the previous done is accepted.
  task automatic run_op(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                        input bit noise, input string tag);
    logic [15:0] exp;
    int done_at;
    int pulses;
    exp     = ref_shift(d, o, a);
    done_at = 0;
    pulses  = 0;
    start = 1'b1; din = d; op = o; amt = a;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        done_at = c;
        chk({tag, " sh_code_done"}, 32'(sh_code), 32'd0);
        chk({tag, " dout"}, 32'(dout), 32'(exp));
        if (noise) begin start = 1'b1; din = 16'hFFFF; op = 2'b01; amt = 4'd1; end
        break;
      end
      chk({tag, " sh_code"}, 32'(sh_code), 32'(o));
      if (noise) begin start = 1'b1; din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom); end
      @(negedge clk);
      start = 1'b0;
    end
    chk({tag, " latency"}, 32'(done_at), 32'(a) + 32'd1);
    @(negedge clk);
    start = 1'b0;
    if (done) pulses++;
    chk({tag, " done_pulse"}, 32'(pulses), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_dout"}, 32'(dout), 32'(exp));
    chk({tag, " idle_sh_in"}, 32'(sh_in), 32'(exp));
    chk({tag, " idle_sh_code"}, 32'(sh_code), 32'd0);
  endtask

  task automatic idle_gap(input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
      @(negedge clk);
      chk("gap_busy", 32'(busy), 32'd0);
      chk("gap_dout", 32'(dout), 32'(exp));
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  ro;
    logic [3:0]  ra;
    int          dones;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; amt = 4'd0; din = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_sh_in", 32'(sh_in), 32'd0);
    chk("rst_sh_code", 32'(sh_code), 32'd0);
    reset_n = 1'b1;

    run_op(16'h0001, 2'b01, 4'd4,  1'b0, "lsl");
    run_op(16'h8000, 2'b11, 4'd3,  1'b0, "asr");
    run_op(16'h8000, 2'b10, 4'd3,  1'b0, "lsr");
    run_op(16'h8000, 2'b10, 4'd15, 1'b0, "lsr_max");
    run_op(16'hABCD, 2'b01, 4'd0,  1'b0, "zero");
    run_op(16'h0003, 2'b01, 4'd2,  1'b1, "ignored");
    chk("ignored_const", 32'(dout), 32'h000C);
    run_op(16'h1234, 2'b00, 4'd5,  1'b0, "pass");
    idle_gap(3, 16'h1234);

    // Abort during the third SHIFT cycle.
    start = 1'b1; din = 16'h00FF; op = 2'b01; amt = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sh_code", 32'(sh_code), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 1) reset_n = 1'b1;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle_dout", 32'(dout), 32'd0);
    run_op(16'h00FF, 2'b01, 4'd8, 1'b0, "after_abort");

    for (int n = 0; n < 40; n++) begin
      rd = 16'($urandom);
      ro = 2'($urandom);
      ra = 4'($urandom);
      run_op(rd, ro, ra, 1'($urandom), "rand");
      if (($urandom % 4) == 0) idle_gap(int'($urandom_range(1, 3)), ref_shift(rd, ro, ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
